postif_ibuf: RTL and testbench

Parametrised instruction buffer between the fetch stage (pc → postif_id handshake) and the decoder (id). It replaces the postif pass-through and decouples fetch from decode stalls. It queues {pc, inst, exception_type} triples in a circular FIFO. It also raises an early fetch stall so that in-flight cache requests always find space.

---
 rtl/cpu_pkg.sv | 14 +
 rtl/ibuf_ram.sv | 28 ++
 rtl/postif_ibuf.sv | 99 +++++++++
 tb/tb_postif_ibuf.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU package: fetch/decode instruction-buffer entry type and default sizing.
package cpu_pkg;

    // One buffered fetch result.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] exception_type;
    } ibuf_entry_t;

    localparam int unsigned IBUF_DEPTH_DEFAULT = 8;
    localparam int unsigned IBUF_SKID_DEFAULT  = 2;

endpackage

// File: rtl/ibuf_ram.sv
// Instruction-buffer storage: DEPTH x 96-bit register array with one write port and one
// asynchronous read port. Contents are intentionally not reset.
module ibuf_ram
    import cpu_pkg::*;
#(
    parameter int unsigned DEPTH = IBUF_DEPTH_DEFAULT,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        we,
    input  logic [AW-1:0] waddr,
    input  ibuf_entry_t wdata,
    input  logic [AW-1:0] raddr,
    output ibuf_entry_t rdata
);

    ibuf_entry_t mem [DEPTH];

    // Single write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/postif_ibuf.sv
// Instruction buffer between fetch and decode. Circular FIFO of {pc, inst, exception_type}
// with an early fetch stall leaving SKID free slots for in-flight requests.
// Optional feature: define IBUF_BYPASS_EN to forward a delivery straight to the outputs when
// the buffer is empty (0-cycle latency); otherwise latency is always 1 cycle.
module postif_ibuf
    import cpu_pkg::*;
#(
    parameter int unsigned DEPTH = IBUF_DEPTH_DEFAULT,
    parameter int unsigned SKID  = IBUF_SKID_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush_i,
    input  logic                     inst_valid_i,
    input  logic [31:0]              pc_i,
    input  logic [31:0]              inst_i,
    input  logic [31:0]              exception_type_i,
    input  logic                     id_stall_i,
    output logic                     inst_valid_o,
    output logic [31:0]              pc_o,
    output logic [31:0]              inst_o,
    output logic [31:0]              exception_type_o,
    output logic                     postif_stall_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;

    ibuf_entry_t in_entry, head_entry, out_entry;
    logic        empty, bypass, bypass_take, pop_mem, push;

    assign in_entry = '{pc: pc_i, inst: inst_i, exception_type: exception_type_i};
    assign empty    = (count_q == '0);

    ibuf_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr_q),
        .wdata (in_entry),
        .raddr (rd_ptr_q),
        .rdata (head_entry)
    );

    // Head selection, bypass decision and push/pop qualification.
    always_comb begin
        bypass = 1'b0;
`ifdef IBUF_BYPASS_EN
        bypass = empty & inst_valid_i & ~flush_i;
`endif
        // A bypassed triple that decode accepts is consumed without touching storage.
        bypass_take = bypass & ~id_stall_i;
        pop_mem     = ~empty & ~id_stall_i & ~flush_i;
        push        = inst_valid_i & ~flush_i & ~bypass_take &
                      ((count_q < CW'(DEPTH)) | pop_mem);

        inst_valid_o = ~empty | bypass;
        out_entry    = bypass ? in_entry : head_entry;
        if (!inst_valid_o) begin
            out_entry = '0;
        end
    end

    assign pc_o             = out_entry.pc;
    assign inst_o           = out_entry.inst;
    assign exception_type_o = out_entry.exception_type;

    // Pointer and occupancy update; flush returns the buffer to its reset state.
    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_mem) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            unique case ({push, pop_mem})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Stall depends on registered occupancy only.
    assign postif_stall_o = (count_q >= CW'(DEPTH - SKID));
    assign count_o        = count_q;

endmodule

// File: tb/tb_postif_ibuf.sv
// Directed self-checking bench for postif_ibuf (DEPTH = 8, SKID = 2).
module tb_postif_ibuf;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned SKID  = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush_i;
    logic        inst_valid_i;
    logic [31:0] pc_i, inst_i, exception_type_i;
    logic        id_stall_i;
    logic        inst_valid_o;
    logic [31:0] pc_o, inst_o, exception_type_o;
    logic        postif_stall_o;
    logic [3:0]  count_o;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    postif_ibuf #(
        .DEPTH (DEPTH),
        .SKID  (SKID)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .flush_i          (flush_i),
        .inst_valid_i     (inst_valid_i),
        .pc_i             (pc_i),
        .inst_i           (inst_i),
        .exception_type_i (exception_type_i),
        .id_stall_i       (id_stall_i),
        .inst_valid_o     (inst_valid_o),
        .pc_o             (pc_o),
        .inst_o           (inst_o),
        .exception_type_o (exception_type_o),
        .postif_stall_o   (postif_stall_o),
        .count_o          (count_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one delivery; inst and exception are derived from pc so they can be predicted.
    task automatic drive(input logic v, input logic [31:0] pc);
        inst_valid_i     = v;
        pc_i             = pc;
        inst_i           = ~pc;
        exception_type_i = pc + 32'd1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] q[$];
    logic [31:0] exp_pc;
    int          pushed, popped;
    logic        push_now;

    initial begin
        rst = 1'b1;
        flush_i = 1'b0;
        id_stall_i = 1'b0;
        drive(1'b0, 32'h0);
        tick();
        tick();
        rst = 1'b0;

        // Reset then idle
        check("rst_valid", {31'd0, inst_valid_o}, 32'd0);
        check("rst_count", {28'd0, count_o}, 32'd0);
        check("rst_stall", {31'd0, postif_stall_o}, 32'd0);
        check("rst_pc", pc_o, 32'd0);
        check("rst_inst", inst_o, 32'd0);
        check("rst_exc", exception_type_o, 32'd0);

        // Streaming
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'hBFC0_0000 + 32'(4 * i));
`ifdef IBUF_BYPASS_EN
            #1;
            check("stream_byp_pc", pc_o, 32'hBFC0_0000 + 32'(4 * i));
            check("stream_byp_valid", {31'd0, inst_valid_o}, 32'd1);
            tick();
            check("stream_byp_count", {28'd0, count_o}, 32'd0);
`else
            tick();
            check("stream_pc", pc_o, 32'hBFC0_0000 + 32'(4 * i));
            check("stream_inst", inst_o, ~(32'hBFC0_0000 + 32'(4 * i)));
            check("stream_exc", exception_type_o, 32'hBFC0_0001 + 32'(4 * i));
            check("stream_count", {28'd0, count_o}, 32'd1);
`endif
        end
        drive(1'b0, 32'h0);
        tick();
        check("stream_end_count", {28'd0, count_o}, 32'd0);
        check("stream_end_valid", {31'd0, inst_valid_o}, 32'd0);
        check("stream_end_pc", pc_o, 32'd0);

        // Fill and backpressure
        id_stall_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 32'h1000 + 32'(4 * i));
            tick();
            check("fill_count", {28'd0, count_o}, 32'(i + 1));
            check("fill_stall", {31'd0, postif_stall_o}, (i + 1 >= 6) ? 32'd1 : 32'd0);
        end
        check("fill_head", pc_o, 32'h1000);
        drive(1'b1, 32'h2000);
        tick();
        check("over_count", {28'd0, count_o}, 32'd8);
        check("over_head", pc_o, 32'h1000);

        // Full simultaneous push/pop
        id_stall_i = 1'b0;
        drive(1'b1, 32'h100);
        tick();
        check("pp_count", {28'd0, count_o}, 32'd8);
        check("pp_head", pc_o, 32'h1004);
        drive(1'b0, 32'h0);
        for (int k = 0; k < 8; k++) begin
            exp_pc = (k < 7) ? 32'h1004 + 32'(4 * k) : 32'h100;
            check("drain_pc", pc_o, exp_pc);
            tick();
        end
        check("drain_count", {28'd0, count_o}, 32'd0);
        check("drain_stall", {31'd0, postif_stall_o}, 32'd0);

        // Wrap-around with random decode stalls
        pushed = 0;
        popped = 0;
        for (int c = 0; c < 300 && !(pushed == 20 && q.size() == 0); c++) begin
            push_now = (pushed < 20) && !postif_stall_o;
            drive(push_now, 32'h8000 + 32'(4 * pushed));
            id_stall_i = 1'($urandom_range(0, 1));
            #1;
            if (push_now) begin
                q.push_back(pc_i);
                pushed++;
            end
            if (inst_valid_o && !id_stall_i) begin
                if (q.size() == 0) begin
                    check("wrap_spurious", pc_o, 32'hFFFF_FFFF);
                end else begin
                    check("wrap_pc", pc_o, q.pop_front());
                    popped++;
                end
            end
            tick();
        end
        drive(1'b0, 32'h0);
        id_stall_i = 1'b0;
        check("wrap_popped", 32'(popped), 32'd20);
        check("wrap_count", {28'd0, count_o}, 32'd0);

        // Flush
        id_stall_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 32'h3000 + 32'(4 * i));
            tick();
        end
        check("pre_flush_count", {28'd0, count_o}, 32'd5);
        flush_i = 1'b1;
        drive(1'b1, 32'h4000);
        #1;
        check("flush_cycle_valid", {31'd0, inst_valid_o}, 32'd1);
        check("flush_cycle_pc", pc_o, 32'h3000);
        tick();
        flush_i = 1'b0;
        check("flush_count", {28'd0, count_o}, 32'd0);
        check("flush_valid", {31'd0, inst_valid_o}, 32'd0);
        drive(1'b1, 32'hBFC0_0380);
        tick();
        drive(1'b0, 32'h0);
        check("post_flush_count", {28'd0, count_o}, 32'd1);
        id_stall_i = 1'b0;
        #1;
        check("post_flush_pc", pc_o, 32'hBFC0_0380);
        tick();
        check("post_flush_empty", {28'd0, count_o}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
